pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles three events:
- load-use hazards detected in ID;
- taken branches resolved in EX;
- multi-cycle data-memory accesses in MEM, with a timeout.

It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_W, 5, register-specifier width.
- MEM_TIMEOUT, 15, max consecutive dmem wait cycles before the error state (1..255).
- CNT_W, 16, stall_cnt width.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rs  input  REG_W  source register 1 of the instruction in ID.
- id_rt  input  REG_W  source register 2 of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_desreg  input  REG_W  destination register of the instruction in EX.
- ex_memread  input  1  EX instruction is a load (Memtoreg).
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- mem_req  input  1  instruction in MEM accesses data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_en  output  1  PC update enable.
- ifid_en  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID loads a NOP.
- idex_en  output  1  ID/EX load enable.
- idex_flush  output  1  ID/EX loads a bubble (Regwrite=0, Memtoreg=0, no mem op).
- exmem_en  output  1  EX/MEM load enable.
- memwb_en  output  1  MEM/WB load enable.
- memwb_bubble  output  1  MEM/WB loads Regwrite=0, Memtoreg=0.
- mem_timeout  output  1  sticky error flag.
- stall_cnt  output  CNT_W  saturating count of cycles with pc_en=0.
- state_o  output  2  current state: 0 RUN, 1 MEM_WAIT, 2 ERR.

Behaviour:
- Controls are combinational from (state, inputs). State, wait counter, mem_timeout and stall_cnt are registered.
- Reset (sync, while reset=1):
  - Next state is RUN; wait_cnt=0, stall_cnt=0, mem_timeout=0.
  - Outputs during reset: pc_en=0, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1, memwb_bubble=1. Bubbles fill the pipe.
  - Reset mid-MEM_WAIT or in ERR returns to RUN on the next edge.
- Defaults in RUN: all *_en=1, all flush/bubble=0.
- load_use = ex_memread and ex_desreg≠0 and (ex_desreg==id_rs or (id_uses_rt and ex_desreg==id_rt)).
- RUN priority, highest first:
  1. mem_req and not mem_ready:
     - Next state MEM_WAIT, wait_cnt←1.
     - All *_en=0 this cycle, except memwb_en=1 with memwb_bubble=1.
     - No flushes.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, all enables 1. This gives a 2-cycle penalty. A load-use hazard in the same cycle is ignored because the ID instruction is squashed.
  3. load_use: pc_en=0, ifid_en=0, idex_flush=1. This is a 1-cycle stall; on the next cycle the hazard clears because EX holds the bubble.
- MEM_WAIT:
  - Pipeline frozen: pc_en=ifid_en=idex_en=exmem_en=0; memwb_en=1 with memwb_bubble=1.
  - If mem_ready=1: the freeze is released this same cycle (all enables 1, no flush/bubble) and the next state is RUN. ex_branch_taken and load_use are honoured on this cycle with the RUN rules above.
  - Else if wait_cnt==MEM_TIMEOUT: next state ERR.
  - Else wait_cnt←wait_cnt+1.
  - Total freeze = number of wait cycles until mem_ready. A zero-wait access (mem_ready with mem_req in RUN) causes no stall.
- ERR:
  - All *_en=0; memwb_en=1 with memwb_bubble=1.
  - mem_timeout=1; the state is held until reset. Inputs are ignored.
- stall_cnt increments on every non-reset cycle with pc_en=0, saturating at 2^CNT_W−1 with no wrap.
- mem_ready without mem_req is ignored in RUN.

Test Plan:
- Reset: hold reset 2 cycles, then release → cycle 1 after release: state_o=0, pc_en=1, all flush/bubble=0, stall_cnt=0, mem_timeout=0.
- Load-use: ex_memread=1, ex_desreg=5, id_rs=5 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle, stall_cnt=1. Repeat with ex_desreg=0 → no stall. Repeat with id_rt=5 and id_uses_rt=0 → no stall.
- Branch: ex_branch_taken=1 together with the load-use condition → ifid_flush=1, idex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high → enables 0 and memwb_bubble=1 for 3 cycles, state_o=1, release on the 4th cycle, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready never asserted → ERR entered after 4 wait cycles, mem_timeout=1 and held for 20 cycles. A 1-cycle reset pulse → RUN, mem_timeout=0.
- Saturation: CNT_W=4, 20 load-use stalls → stall_cnt=15 and held.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage stall/flush sequencer (load-use, taken branch, dmem wait with timeout); in: hazard/mem status, out: stage enables/flushes, mem_timeout, stall_cnt, state_o
module pipe_hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] ex_desreg,
   input  logic             ex_memread,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             memwb_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       state_o
);
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_t;
   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             load_use, freeze, lu_stall;
   always_comb begin
      load_use      = ex_memread && ex_desreg != '0 &&
                      (ex_desreg == id_rs || (id_uses_rt && ex_desreg == id_rt));
      freeze        = state_q == ERR || (!mem_ready && (state_q == MEM_WAIT || mem_req));
      lu_stall      = load_use && !ex_branch_taken;
      pc_en         = !reset && !freeze && !lu_stall;
      ifid_en       = reset || (!freeze && !lu_stall);
      ifid_flush    = reset || (!freeze && ex_branch_taken);
      idex_en       = reset || !freeze;
      idex_flush    = reset || (!freeze && (ex_branch_taken || load_use));
      exmem_en      = reset || !freeze;
      memwb_en      = 1'b1;
      memwb_bubble  = reset || freeze;
      state_d       = (state_q == RUN && mem_req && !mem_ready) ? MEM_WAIT :
                      (state_q == MEM_WAIT && mem_ready) ? RUN :
                      (state_q == MEM_WAIT && wait_cnt_q == TIMEOUT) ? ERR : state_q;
      wait_cnt_d    = (state_d != MEM_WAIT) ? 8'd0 :
                      (state_q == MEM_WAIT) ? wait_cnt_q + 8'd1 : 8'd1;
      mem_timeout_d = mem_timeout_q || state_d == ERR;
      stall_cnt_d   = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end
   assign mem_timeout = mem_timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign state_o     = state_q;
endmodule
